// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks RF debug port 0..REG_CNT-1 and streams tagged values over valid/ready; RF_DUMP_CSUM_EN adds a trailing checksum beat
module rf_dump_reader #(
  parameter int REG_CNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  dbg_reg_ra,
  input  logic [31:0] dbg_reg_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data,
  output logic        out_last
);
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] idx, idx_q;
  logic [31:0] data_q;
  logic hs, is_last;
`ifdef RF_DUMP_CSUM_EN
  logic [31:0] csum;
`endif
  assign hs = out_valid && out_ready;
  assign is_last = idx == 5'(REG_CNT - 1);
  assign dbg_reg_ra = idx;
  assign busy = state == FETCH || state == SEND || state == CSUM;
  assign done = state == DONE;
  assign out_valid = state == SEND || state == CSUM;
`ifdef RF_DUMP_CSUM_EN
  assign out_last = state == CSUM;
  assign out_idx = state == CSUM ? 5'd0 : idx_q;
  assign out_data = state == CSUM ? csum : data_q;
`else
  assign out_last = state == SEND && is_last;
  assign out_idx = idx_q;
  assign out_data = data_q;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? FETCH : IDLE;
      FETCH: state_nx = SEND;
`ifdef RF_DUMP_CSUM_EN
      SEND:  state_nx = hs ? (is_last ? CSUM : FETCH) : SEND;
`else
      SEND:  state_nx = hs ? (is_last ? DONE : FETCH) : SEND;
`endif
      CSUM:  state_nx = hs ? DONE : CSUM;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      idx_q <= '0;
      data_q <= '0;
`ifdef RF_DUMP_CSUM_EN
      csum <= '0;
`endif
    end else begin
      if (state == IDLE || state == DONE)
        idx <= '0;
      else if (state == SEND && hs && !is_last)
        idx <= idx + 5'd1;
      if (state == FETCH) begin
        data_q <= dbg_reg_rd;
        idx_q <= idx;
      end
`ifdef RF_DUMP_CSUM_EN
      if (state == IDLE && start)
        csum <= '0;
      else if (state == FETCH)
        csum <= csum + dbg_reg_rd;
`endif
    end
  end
endmodule

// File: doc/rf_dump_reader.md
# rf_dump_reader

Sequential reader on the register file's debug read port (`dbg_reg_ra` / `dbg_reg_rd`) for post-run inspection. On a `start` pulse it walks registers 0..REG_CNT-1 and streams each value, tagged with its index, over a valid/ready interface. The block sits beside the CPU core and feeds the debug/trace path.

## Interface
- `REG_CNT`, default 32: number of registers dumped, starting at index 0. Legal range 1..32.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a dump. Sampled only in IDLE.
- `busy` out 1: high from FETCH through the final SEND/CSUM beat.
- `done` out 1: one-cycle pulse after the final beat handshakes.
- `dbg_reg_ra` out 5: debug read address to the RF, equal to the current index register.
- `dbg_reg_rd` in 32: combinational RF debug read data.
- `out_valid` out 1: stream beat valid.
- `out_ready` in 1: stream sink ready.
- `out_idx` out 5: register index of the current beat. 0 on the checksum beat.
- `out_data` out 32: register value, or checksum, of the current beat.
- `out_last` out 1: high on the final beat of a dump.

## Operation
- FSM states and transitions:
  - IDLE: `start` → FETCH with idx=0, and the checksum is cleared.
  - FETCH: drives `dbg_reg_ra`=idx. At the clock edge it captures `dbg_reg_rd` into `out_data` and idx into `out_idx`, then → SEND.
  - SEND: `out_valid`=1.
    - On handshake (`out_valid && out_ready`) with idx==REG_CNT-1: → CSUM if the macro is defined, else → DONE.
    - On any other handshake: idx+1 → FETCH.
    - With no handshake: stay in SEND.
  - CSUM (macro only): `out_valid`=1, `out_data`=checksum, `out_idx`=0, `out_last`=1. Handshake → DONE.
  - DONE: `done`=1 for exactly one cycle, then → IDLE.
- `start` outside IDLE is ignored. That includes `start` in DONE.
- `out_data`, `out_idx` and `out_last` are stable while `out_valid` is high and `out_ready` is low.
- `out_valid` never drops without a handshake except on `rst`.
- Each register is sampled in its own FETCH cycle, so the dump is not an atomic snapshot. A concurrent RF write lands in the dump only if it is written before that register's FETCH edge.
- Register 0 reads as 0 from the RF and is dumped as-is. There is no special casing.
- Checksum: 32-bit running sum of every captured `out_data`, modulo 2^32 (carry discarded), updated at each FETCH capture.

## Timing
- Reset values: state=IDLE, idx=0, `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_idx`=0, `out_data`=0, `dbg_reg_ra`=0, checksum=0.
- `start` sampled at edge T. FETCH occupies cycle T+1, and the first `out_valid` is at T+2.
- Minimum 2 cycles per beat (FETCH + SEND). With `out_ready` held high, beat k is valid at cycle T+2+2k.
- REG_CNT=32 with `out_ready` held high:
  - without macro: last beat at T+64, `done` at T+65, IDLE at T+66;
  - with macro: CSUM beat at T+65, `done` at T+66.
- `rst` mid-dump takes effect at the next edge and overrides everything. A partial stream is abandoned with no `out_last` and no `done`.
- `rst` and `start` in the same cycle: `rst` wins, and the block stays in IDLE.

## Configuration
- `RF_DUMP_CSUM_EN` defined: the CSUM state and checksum register exist. One extra beat follows the last register, and `out_last` is asserted only on that beat.
- `RF_DUMP_CSUM_EN` not defined: there is no checksum logic. `out_last` is asserted on the SEND beat of idx==REG_CNT-1, and beat count equals REG_CNT.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs. All outputs must be 0 and the state IDLE, and `start` during `rst` is ignored.
- Full dump: preload RF reg[i]=0x100+i for i=1..31, hold `out_ready`=1, pulse `start`.
  - 32 beats, `out_idx`=0..31, `out_data`=0 for idx 0 and 0x100+i otherwise.
  - First `out_valid` 2 cycles after `start`, one beat every 2 cycles, `done` single pulse.
- Backpressure: drop `out_ready` for 5 cycles while beat idx=3 is valid. `out_idx`=3 and `out_data`=0x103 must be held, no beat is skipped or duplicated, and 32 beats total.
- Ignored start: re-pulse `start` during the dump and again in the DONE cycle. Exactly 32 beats and one `done`, then IDLE.
- Reset mid-operation: assert `rst` while beat idx=10 is valid. Next cycle `out_valid`=0, `busy`=0, no `done`; a new `start` restarts at idx 0.
- Checksum (`RF_DUMP_CSUM_EN` defined), same preload: 33rd beat has `out_data`=0x000020F0, `out_idx`=0, `out_last`=1, and `out_last` is 0 on all 32 register beats.
